// File: rtl/seq_pp_multiplier.sv
// Iterative partial-product multiplier: DIGIT bits of B per cycle, optional low-column truncation.
// Define SEQ_PP_SELFCHECK_EN to add an exact reference product and err_flag/err_mag outputs.
module seq_pp_multiplier #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGIT       = 2,
  parameter int unsigned APPROX_COLS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
`ifdef SEQ_PP_SELFCHECK_EN
  ,
  output logic                 err_flag,
  output logic [2*WIDTH-1:0]   err_mag
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  // Column j of the product survives only when j >= APPROX_COLS.
  localparam logic [PW-1:0] COL_MASK = {PW{1'b1}} << APPROX_COLS;

  generate
    if (DIGIT == 0) begin : g_bad_digit_zero
      $error("seq_pp_multiplier: DIGIT must be non-zero");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_digit_mult
      $error("seq_pp_multiplier: WIDTH must be a multiple of DIGIT");
    end
    if (APPROX_COLS > 2 * WIDTH) begin : g_bad_approx
      $error("seq_pp_multiplier: APPROX_COLS must be in 0..2*WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   pp_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   p_q;

`ifdef SEQ_PP_SELFCHECK_EN
  logic [PW-1:0]   exact_q;
  logic            err_flag_q;
  logic [PW-1:0]   err_mag_q;
`endif

  // a_q is pre-shifted to the current digit's weight, b_q shifted down so the digit sits at bit 0.
  always_comb begin
    pp_d = '0;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      if (b_q[k]) begin
        pp_d = pp_d + ((a_q << k) & COL_MASK);
      end
    end
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef SEQ_PP_SELFCHECK_EN
      exact_q    <= '0;
      err_flag_q <= 1'b0;
      err_mag_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= PW'(a);
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_RUN;
`ifdef SEQ_PP_SELFCHECK_EN
            exact_q <= PW'(a) * PW'(b);
`endif
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          a_q   <= a_q << DIGIT;
          b_q   <= b_q >> DIGIT;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= S_DONE;
            p_q     <= acc_d;
`ifdef SEQ_PP_SELFCHECK_EN
            err_mag_q  <= exact_q - acc_d;
            err_flag_q <= (exact_q != acc_d);
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign p         = p_q;

`ifdef SEQ_PP_SELFCHECK_EN
  assign err_flag = err_flag_q;
  assign err_mag  = err_mag_q;
`endif

endmodule

// File: tb/tb_seq_pp_multiplier.sv
// Scoreboard bench for seq_pp_multiplier: three configurations, directed vectors.
module tb_seq_pp_multiplier;

  logic        clk;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  irdy;
  logic [2:0]  ov;
  logic [2:0]  bsy;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic [15:0] p0, p1;
  logic [31:0] p2;
`ifdef SEQ_PP_SELFCHECK_EN
  logic [2:0]  ef;
  logic [15:0] em0, em1;
  logic [31:0] em2;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] em;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  seq_pp_multiplier #(.WIDTH(8), .DIGIT(2), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a0), .b(b0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p(p0), .busy(bsy[0])
`ifdef SEQ_PP_SELFCHECK_EN
    , .err_flag(ef[0]), .err_mag(em0)
`endif
  );

  seq_pp_multiplier #(.WIDTH(8), .DIGIT(2), .APPROX_COLS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a1), .b(b1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p(p1), .busy(bsy[1])
`ifdef SEQ_PP_SELFCHECK_EN
    , .err_flag(ef[1]), .err_mag(em1)
`endif
  );

  seq_pp_multiplier #(.WIDTH(16), .DIGIT(4), .APPROX_COLS(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a2), .b(b2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .p(p2), .busy(bsy[2])
`ifdef SEQ_PP_SELFCHECK_EN
    , .err_flag(ef[2]), .err_mag(em2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_p(input logic [1:0] sel);
    case (sel)
      2'd0:    return 32'(p0);
      2'd1:    return 32'(p1);
      default: return p2;
    endcase
  endfunction

`ifdef SEQ_PP_SELFCHECK_EN
  function automatic logic [31:0] get_em(input logic [1:0] sel);
    case (sel)
      2'd0:    return 32'(em0);
      2'd1:    return 32'(em1);
      default: return em2;
    endcase
  endfunction
`endif

  task automatic drive(input logic [1:0] sel, input logic v, input logic [15:0] aa,
                       input logic [15:0] bb);
    case (sel)
      2'd0:    begin a0 = aa[7:0]; b0 = bb[7:0]; end
      2'd1:    begin a1 = aa[7:0]; b1 = bb[7:0]; end
      default: begin a2 = aa;      b2 = bb;      end
    endcase
    iv[sel] = v;
  endtask

  task automatic push_exp(input logic [1:0] sel, input logic [31:0] ep, input logic [31:0] em);
    exp_t e;
    e.p  = ep;
    e.em = em;
    case (sel)
      2'd0:    sb0.push_back(e);
      2'd1:    sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  // Pops the oldest expectation for an instance whose output handshake completes at the next edge.
  task automatic mon_check(input logic [1:0] sel);
    exp_t e;
    int   depth;
    case (sel)
      2'd0:    depth = sb0.size();
      2'd1:    depth = sb1.size();
      default: depth = sb2.size();
    endcase
    if (depth == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL out_unexpected dut%0d: got p=0x%0h, expected no output", sel, get_p(sel));
    end else begin
      case (sel)
        2'd0:    e = sb0.pop_front();
        2'd1:    e = sb1.pop_front();
        default: e = sb2.pop_front();
      endcase
      chk($sformatf("sb_p_dut%0d", sel), 64'(get_p(sel)), 64'(e.p));
`ifdef SEQ_PP_SELFCHECK_EN
      chk($sformatf("sb_err_mag_dut%0d", sel), 64'(get_em(sel)), 64'(e.em));
      chk($sformatf("sb_err_flag_dut%0d", sel), 64'(ef[sel]), 64'(e.em != 32'd0));
`endif
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && ordy[i]) mon_check(2'(i));
    end
  end

  // One operation: accept, watch latency and in_ready, optionally stall in DONE, then hand off.
  task automatic run_op(input logic [1:0] sel, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] ep, input logic [31:0] em, input int n_lat,
                        input logic stall);
    int   cyc;
    logic saw_ready;
    push_exp(sel, ep, em);
    ordy[sel] = ~stall;
    drive(sel, 1'b1, aa, bb);
    cyc = 0;
    while (!irdy[sel] && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("accept_wait_dut%0d", sel), 64'(cyc < 64), 64'(1));
    @(posedge clk); #1;
    drive(sel, 1'b0, ~aa, ~bb);
    saw_ready = 1'b0;
    cyc = 0;
    while (!ov[sel] && cyc < 64) begin
      saw_ready = saw_ready | irdy[sel];
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency_dut%0d", sel), 64'(cyc), 64'(n_lat));
    chk($sformatf("in_ready_run_dut%0d", sel), 64'(saw_ready | irdy[sel]), 64'(0));
    chk($sformatf("busy_done_dut%0d", sel), 64'(bsy[sel]), 64'(1));
    chk($sformatf("p_done_dut%0d", sel), 64'(get_p(sel)), 64'(ep));
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        drive(sel, 1'((i % 2) == 0), 16'($urandom), 16'($urandom));
        @(posedge clk); #1;
        chk($sformatf("stall_p_dut%0d_c%0d", sel, i), 64'(get_p(sel)), 64'(ep));
        chk($sformatf("stall_ov_dut%0d_c%0d", sel, i), 64'(ov[sel]), 64'(1));
        chk($sformatf("stall_rdy_dut%0d_c%0d", sel, i), 64'(irdy[sel]), 64'(0));
      end
      drive(sel, 1'b0, 16'd0, 16'd0);
      ordy[sel] = 1'b1;
    end
    @(posedge clk); #1;
    chk($sformatf("idle_ov_dut%0d", sel), 64'(ov[sel]), 64'(0));
    chk($sformatf("idle_rdy_dut%0d", sel), 64'(irdy[sel]), 64'(1));
  endtask

  initial begin
    rst  = 1'b1;
    iv   = 3'b000;
    ordy = 3'b000;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ov", 64'(ov), 64'(0));
    chk("reset_busy", 64'(bsy), 64'(0));
    chk("reset_rdy_in_rst", 64'(irdy), 64'(0));
    chk("reset_p0", 64'(p0), 64'(0));
    chk("reset_p2", 64'(p2), 64'(0));
    rst = 1'b0;
    #1;
    chk("reset_rdy_after", 64'(irdy), 64'(3'b111));

    // Exact 8x8, 2 bits per cycle.
    run_op(2'd0, 16'd200, 16'd150, 32'd30000, 32'd0, 4, 1'b0);
    run_op(2'd0, 16'd255, 16'd255, 32'd65025, 32'd0, 4, 1'b0);
    run_op(2'd0, 16'd0,   16'd255, 32'd0,     32'd0, 4, 1'b0);
    run_op(2'd0, 16'd1,   16'd1,   32'd1,     32'd0, 4, 1'b0);
    run_op(2'd0, 16'd13,  16'd11,  32'd143,   32'd0, 4, 1'b1);
    run_op(2'd0, 16'd128, 16'd2,   32'd256,   32'd0, 4, 1'b0);

    // Reset on the second RUN edge discards the operation.
    drive(2'd0, 1'b1, 16'd7, 16'd9);
    @(posedge clk); #1;
    chk("rst_test_accepted", 64'(bsy[0]), 64'(1));
    drive(2'd0, 1'b0, 16'd0, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ov", 64'(ov[0]), 64'(0));
    chk("rst_mid_busy", 64'(bsy[0]), 64'(0));
    chk("rst_mid_p", 64'(p0), 64'(0));
    chk("rst_mid_rdy", 64'(irdy[0]), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_mid_rdy_after", 64'(irdy[0]), 64'(1));
    run_op(2'd0, 16'd3, 16'd5, 32'd15, 32'd0, 4, 1'b0);

    // Approximate: columns 0..3 dropped.
    run_op(2'd1, 16'h000F, 16'h000F, 32'd176,   32'd49, 4, 1'b0);
    run_op(2'd1, 16'd255,  16'd255,  32'd64976, 32'd49, 4, 1'b0);
    run_op(2'd1, 16'd1,    16'd1,    32'd0,     32'd1,  4, 1'b0);
    run_op(2'd1, 16'd16,   16'd1,    32'd16,    32'd0,  4, 1'b0);

    // Exact 16x16, 4 bits per cycle.
    run_op(2'd2, 16'hFFFF, 16'h0002, 32'h0001_FFFE, 32'd0, 4, 1'b0);
    run_op(2'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'd0, 4, 1'b0);
    run_op(2'd2, 16'h1234, 16'h0010, 32'h0001_2340, 32'd0, 4, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb0_drained", 64'(sb0.size()), 64'(0));
    chk("sb1_drained", 64'(sb1.size()), 64'(0));
    chk("sb2_drained", 64'(sb2.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

endmodule
